mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (port 0, read-only) and load/store
// (port 1) share one memory through a fixed four-cycle IDLE/ISSUE/CAPTURE/DONE sequence.
module mem_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [3:0]  p1_wmask,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflicts
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       grant;
    logic       last_grant;
    logic       pick;
    logic [3:0] wmask_q;
    logic       any_req;
    logic       both_req;

    assign any_req  = p0_req | p1_req;
    assign both_req = p0_req & p1_req;

    // On a tie, fixed priority favours port 1; round-robin favours whoever was not served last.
    always_comb begin
        pick = p1_req;
        if (both_req) begin
            pick = (PRIO_MODE == 1) ? 1'b1 : ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rstrb  = 1'b0;
        mem_wmask  = 4'b0000;
        p0_done    = 1'b0;
        p1_done    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = CAPTURE;
                mem_rstrb  = (wmask_q == 4'b0000);
                mem_wmask  = wmask_q;
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                p0_done    = ~grant;
                p1_done    = grant;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A zero latched mask marks the access as a read; port 0 can never write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            wmask_q    <= 4'b0000;
        end else if (state == IDLE && any_req) begin
            grant      <= pick;
            last_grant <= pick;
            mem_addr   <= pick ? p1_addr : p0_addr;
            wmask_q    <= pick ? p1_wmask : 4'b0000;
            if (pick) begin
                mem_wdata <= p1_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p0_rdata <= 32'h0;
            p1_rdata <= 32'h0;
        end else if (state == CAPTURE && wmask_q == 4'b0000) begin
            if (grant) begin
                p1_rdata <= mem_rdata;
            end else begin
                p0_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflicts <= 16'h0;
        end else if (state == IDLE && both_req && conflicts != 16'hFFFF) begin
            conflicts <= conflicts + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance backed by a byte-maskable memory
// model and a fixed-priority instance backed by an address-derived read model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr, p1_wdata;
    logic [3:0]  p1_wmask;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [15:0] conflicts;

    logic        b_p0_req, b_p1_req;
    logic [31:0] b_p0_addr, b_p1_addr;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_p0_done, b_p1_done;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_rstrb;
    logic [3:0]  b_mem_wmask;
    logic [15:0] b_conflicts;

    mem_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflicts(conflicts)
    );

    mem_arbiter #(.PRIO_MODE(1)) dut_fixed (
        .clk(clk), .resetn(resetn),
        .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_rdata(b_p0_rdata), .p0_done(b_p0_done),
        .p1_req(b_p1_req), .p1_addr(b_p1_addr), .p1_wmask(4'b0000), .p1_wdata(32'h0),
        .p1_rdata(b_p1_rdata), .p1_done(b_p1_done),
        .mem_addr(b_mem_addr), .mem_rstrb(b_mem_rstrb), .mem_wmask(b_mem_wmask),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .conflicts(b_conflicts)
    );

    // Memory device: 256 words, one-cycle read latency, byte-masked writes, plus a bench load port.
    logic [31:0] mem [256];
    logic        load_en;
    logic [7:0]  load_idx;
    logic [31:0] load_val;

    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (b_mem_rstrb) b_mem_rdata <= ~b_mem_addr;
    end

    // Reference model state, kept at transaction level.
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [256];
    logic        exp_last;
    int          exp_conf;
    logic [31:0] exp_r0, exp_r1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_last = 1'b1;
        exp_conf = 0;
        exp_r0   = 32'h0;
        exp_r1   = 32'h0;
    endtask

    function automatic logic model_grant(input logic r0, input logic r1, input int mode);
        if (r0 && r1) return (mode == 1) ? 1'b1 : ~exp_last;
        return r1;
    endfunction

    task automatic load_word(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        load_en  = 1'b1;
        load_idx = idx[7:0];
        load_val = val;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        n_vec++;
        if ({p0_rdata, p1_rdata, p0_done, p1_done, mem_addr, mem_rstrb, mem_wmask, mem_wdata, conflicts} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %h expected all zero",
                     {p0_rdata, p1_rdata, p0_done, p1_done, mem_addr, mem_rstrb, mem_wmask, mem_wdata, conflicts});
        end
        n_vec++;
        if ({b_p0_rdata, b_p1_rdata, b_p0_done, b_p1_done, b_mem_addr, b_mem_rstrb, b_mem_wmask, b_conflicts} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs_fixed: got nonzero outputs, expected all zero");
        end
        tick();
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_read_p0();
        load_word(4, 32'hDEADBEEF);
        p0_req = 1'b1; p0_addr = 32'h10;
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask, mem_addr} !== {1'b1, 4'b0000, 32'h10}) begin
            n_err++;
            $display("[TB] FAIL rd_issue: got rstrb=%b wmask=%b addr=%h expected 1 0000 00000010", mem_rstrb, mem_wmask, mem_addr);
        end
        tick();
        n_vec++;
        if ({mem_rstrb, p0_done, p1_done} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL rd_capture: got rstrb/done0/done1=%b expected 000", {mem_rstrb, p0_done, p1_done});
        end
        tick();
        n_vec++;
        if ({p0_done, p1_done, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_err++;
            $display("[TB] FAIL rd_done: got done=%b%b rdata=%h expected 10 deadbeef", p0_done, p1_done, p0_rdata);
        end
        p0_req = 1'b0;
        tick();
        n_vec++;
        if (p0_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rd_done_width: got %b expected 0", p0_done);
        end
        exp_last = 1'b0;
        exp_r0   = 32'hDEADBEEF;
    endtask

    task automatic test_write_p1();
        logic [31:0] merged;
        merged = {ref_mem[8][31:16], 16'hABCD};
        p1_req = 1'b1; p1_addr = 32'h20; p1_wmask = 4'b0011; p1_wdata = 32'h1234ABCD;
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask, mem_addr, mem_wdata} !== {1'b0, 4'b0011, 32'h20, 32'h1234ABCD}) begin
            n_err++;
            $display("[TB] FAIL wr_issue: got rstrb=%b wmask=%b addr=%h wdata=%h expected 0 0011 00000020 1234abcd",
                     mem_rstrb, mem_wmask, mem_addr, mem_wdata);
        end
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask} !== 5'b0) begin
            n_err++;
            $display("[TB] FAIL wr_capture: got rstrb=%b wmask=%b expected 0 0000", mem_rstrb, mem_wmask);
        end
        tick();
        n_vec++;
        if ({p0_done, p1_done, p1_rdata} !== {2'b01, exp_r1}) begin
            n_err++;
            $display("[TB] FAIL wr_done: got done=%b%b p1_rdata=%h expected 01 %h", p0_done, p1_done, p1_rdata, exp_r1);
        end
        ref_mem[8] = merged;
        exp_last = 1'b1;
        p1_wmask = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        n_vec++;
        if ({p1_done, p1_rdata} !== {1'b1, merged}) begin
            n_err++;
            $display("[TB] FAIL wr_readback: got done=%b rdata=%h expected 1 %h", p1_done, p1_rdata, merged);
        end
        exp_r1 = merged;
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_random(input int n);
        logic r0, r1, g, drop, wr;
        int sel, idx;
        logic [31:0] a0, a1, wd, exp_addr, exp_rd;
        logic [3:0] wm;
        for (int t = 0; t < n; t++) begin
            sel  = $urandom_range(1, 3);
            r0   = (sel & 1) != 0;
            r1   = (sel & 2) != 0;
            a0   = $urandom; a1 = $urandom; wd = $urandom;
            wm   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            drop = ($urandom_range(0, 3) == 0);
            g    = model_grant(r0, r1, 0);
            if (r0 && r1 && exp_conf < 65535) exp_conf++;
            exp_last = g;
            exp_addr = g ? a1 : a0;
            wr       = g && (wm != 4'b0000);
            idx      = int'(exp_addr[9:2]);
            exp_rd   = ref_mem[idx];
            p0_req = r0; p0_addr = a0; p1_req = r1; p1_addr = a1; p1_wmask = wm; p1_wdata = wd;
            tick();
            if (drop) begin p0_req = 1'b0; p1_req = 1'b0; end
            n_vec++;
            if ({mem_addr, mem_rstrb, mem_wmask} !== {exp_addr, ~wr, wr ? wm : 4'b0000} || (wr && mem_wdata !== wd)) begin
                n_err++;
                $display("[TB] FAIL rand_issue[%0d]: got addr=%h rstrb=%b wmask=%b wdata=%h expected %h %b %b %h",
                         t, mem_addr, mem_rstrb, mem_wmask, mem_wdata, exp_addr, ~wr, wr ? wm : 4'b0000, wd);
            end
            tick();
            n_vec++;
            if ({mem_rstrb, mem_wmask, p0_done, p1_done} !== 7'b0) begin
                n_err++;
                $display("[TB] FAIL rand_capture[%0d]: got %b expected 0000000", t, {mem_rstrb, mem_wmask, p0_done, p1_done});
            end
            tick();
            if (!wr) begin
                if (g) exp_r1 = exp_rd; else exp_r0 = exp_rd;
            end else begin
                for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
            n_vec++;
            if ({p0_done, p1_done, p0_rdata, p1_rdata} !== {~g, g, exp_r0, exp_r1}) begin
                n_err++;
                $display("[TB] FAIL rand_done[%0d]: got done=%b%b r0=%h r1=%h expected %b%b %h %h",
                         t, p0_done, p1_done, p0_rdata, p1_rdata, ~g, g, exp_r0, exp_r1);
            end
            p0_req = 1'b0; p1_req = 1'b0; p1_wmask = 4'b0000;
            tick();
            n_vec++;
            if ({p0_done, p1_done, conflicts} !== {2'b00, 16'(exp_conf)}) begin
                n_err++;
                $display("[TB] FAIL rand_idle[%0d]: got done=%b%b conflicts=%0d expected 00 %0d", t, p0_done, p1_done, conflicts, exp_conf);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic g;
        logic [31:0] a0, a1, exp_rd;
        resetn = 1'b0;
        a0 = $urandom; a1 = $urandom;
        p0_req = 1'b1; p0_addr = a0; p1_req = 1'b1; p1_addr = a1; p1_wmask = 4'b0000;
        tick();
        resetn = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            g = model_grant(1'b1, 1'b1, 0);
            exp_last = g;
            exp_conf++;
            exp_rd = ref_mem[int'(g ? a1[9:2] : a0[9:2])];
            tick();
            n_vec++;
            if ({mem_addr, mem_rstrb} !== {g ? a1 : a0, 1'b1}) begin
                n_err++;
                $display("[TB] FAIL b2b_issue[%0d]: got addr=%h rstrb=%b expected %h 1", k, mem_addr, mem_rstrb, g ? a1 : a0);
            end
            tick();
            tick();
            if (g) exp_r1 = exp_rd; else exp_r0 = exp_rd;
            n_vec++;
            if ({p0_done, p1_done, p0_rdata, p1_rdata} !== {~g, g, exp_r0, exp_r1}) begin
                n_err++;
                $display("[TB] FAIL b2b_done[%0d]: got done=%b%b r0=%h r1=%h expected %b%b %h %h",
                         k, p0_done, p1_done, p0_rdata, p1_rdata, ~g, g, exp_r0, exp_r1);
            end
            tick();
            n_vec++;
            if ({p0_done, p1_done, conflicts} !== {2'b00, 16'(exp_conf)}) begin
                n_err++;
                $display("[TB] FAIL b2b_conflicts[%0d]: got done=%b%b conflicts=%0d expected 00 %0d", k, p0_done, p1_done, conflicts, exp_conf);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
    endtask

    task automatic test_fixed_prio();
        logic [31:0] a1;
        b_p0_req = 1'b1; b_p0_addr = $urandom; b_p1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a1 = $urandom;
            b_p1_addr = a1;
            tick();
            n_vec++;
            if ({b_mem_addr, b_p0_done} !== {a1, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL fixed_issue[%0d]: got addr=%h done0=%b expected %h 0", k, b_mem_addr, b_p0_done, a1);
            end
            tick();
            tick();
            n_vec++;
            if ({b_p0_done, b_p1_done, b_p1_rdata, b_p0_rdata} !== {2'b01, ~a1, 32'h0}) begin
                n_err++;
                $display("[TB] FAIL fixed_done[%0d]: got done=%b%b r1=%h r0=%h expected 01 %h 00000000",
                         k, b_p0_done, b_p1_done, b_p1_rdata, b_p0_rdata, ~a1);
            end
            tick();
            n_vec++;
            if ({b_p0_done, b_conflicts} !== {1'b0, 16'(k + 1)}) begin
                n_err++;
                $display("[TB] FAIL fixed_idle[%0d]: got done0=%b conflicts=%0d expected 0 %0d", k, b_p0_done, b_conflicts, k + 1);
            end
        end
        b_p0_req = 1'b0; b_p1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midway();
        logic [31:0] a;
        p0_req = 1'b1; p0_addr = $urandom;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({p0_rdata, p1_rdata, p0_done, p1_done, mem_addr, mem_rstrb, mem_wmask, mem_wdata, conflicts} !== '0) begin
            n_err++;
            $display("[TB] FAIL midreset_outputs: got nonzero outputs, expected all zero");
        end
        p0_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({p0_done, p1_done} !== 2'b00) begin
                n_err++;
                $display("[TB] FAIL midreset_done[%0d]: got %b%b expected 00", k, p0_done, p1_done);
            end
        end
        resetn = 1'b1;
        model_reset();
        a = $urandom;
        p0_req = 1'b1; p0_addr = a;
        tick();
        n_vec++;
        if ({mem_rstrb, mem_addr} !== {1'b1, a}) begin
            n_err++;
            $display("[TB] FAIL midreset_reissue: got rstrb=%b addr=%h expected 1 %h", mem_rstrb, mem_addr, a);
        end
        tick();
        tick();
        exp_r0 = ref_mem[int'(a[9:2])];
        exp_last = 1'b0;
        n_vec++;
        if ({p0_done, p0_rdata} !== {1'b1, exp_r0}) begin
            n_err++;
            $display("[TB] FAIL midreset_done_new: got done=%b rdata=%h expected 1 %h", p0_done, p0_rdata, exp_r0);
        end
        p0_req = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        force dut.conflicts = 16'hFFFE;
        #1;
        release dut.conflicts;
        p0_req = 1'b1; p0_addr = $urandom; p1_req = 1'b1; p1_addr = $urandom; p1_wmask = 4'b0000;
        tick();
        n_vec++;
        if (conflicts !== 16'hFFFF) begin
            n_err++;
            $display("[TB] FAIL sat_reach: got %h expected ffff", conflicts);
        end
        tick();
        tick();
        tick();
        tick();
        n_vec++;
        if (conflicts !== 16'hFFFF) begin
            n_err++;
            $display("[TB] FAIL sat_hold: got %h expected ffff", conflicts);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        p0_req = 1'b0; p0_addr = 32'h0; p1_req = 1'b0; p1_addr = 32'h0;
        p1_wmask = 4'b0000; p1_wdata = 32'h0;
        b_p0_req = 1'b0; b_p0_addr = 32'h0; b_p1_req = 1'b0; b_p1_addr = 32'h0;
        load_en = 1'b0; load_idx = 8'h0; load_val = 32'h0;
        model_reset();
        for (int i = 0; i < 256; i++) load_word(i, $urandom);
        test_reset();
        test_read_p0();
        test_write_p1();
        test_random(40);
        test_back_to_back();
        test_fixed_prio();
        test_reset_midway();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
